// File: rtl/game_collision_detector_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_collision_pkg
// Description : Shared types and constants for the frame collision detector.
// Revision    : 1.0 - initial release
// ============================================================================
package game_collision_pkg;

   localparam int N_TARGETS = 3;

   typedef enum logic [0:0] {
      WAIT_FRAME = 1'b0,
      ACCUM      = 1'b1
   } collision_state_t;

endpackage : game_collision_pkg
`default_nettype wire

// File: rtl/game_collision_detector_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_collision_detector_if
// Description : Sprite-enable inputs and per-frame collision report outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_collision_detector_if;
   import game_collision_pkg::*;

   logic                 frame_start;
   logic                 pixel_valid;
   logic                 spaceship_rgb_en;
   logic                 bullet_rgb_en;
   logic [N_TARGETS-1:0] target_rgb_en;
   logic                 clear;
   logic                 collision;
   logic                 collision_bullet;
   logic [N_TARGETS-1:0] hit_target;
   logic                 armed;

   // Master is the video/FSM side that supplies pixels and consumes reports.
   modport master (
      output frame_start, pixel_valid, spaceship_rgb_en, bullet_rgb_en,
             target_rgb_en, clear,
      input  collision, collision_bullet, hit_target, armed
   );

   modport slave (
      input  frame_start, pixel_valid, spaceship_rgb_en, bullet_rgb_en,
             target_rgb_en, clear,
      output collision, collision_bullet, hit_target, armed
   );

endinterface : game_collision_detector_if
`default_nettype wire

// File: rtl/game_collision_detector_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_overlap_counter
// Description : Saturating per-frame overlap counter with threshold compare.
// Revision    : 1.0 - initial release
// ============================================================================
module game_overlap_counter #(
   parameter int CNT_W           = 8,
   parameter int PIXEL_THRESHOLD = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             inc,
   input  wire logic             clr,
   output logic [CNT_W-1:0]      count,
   output logic                  over_threshold
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_thresh  = CNT_W'(PIXEL_THRESHOLD);

   logic [CNT_W-1:0] r_count;

   // A clear still admits the same-cycle pixel so it lands in the new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= inc ? CNT_W'(1) : '0;
      end else if (inc && (r_count != c_cnt_max)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count          = r_count;
   assign over_threshold = (r_count >= c_thresh);

endmodule : game_overlap_counter
`default_nettype wire

// File: rtl/game_collision_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_collision_detector
// Description : Counts sprite overlaps per frame and reports single-cycle
//               collision pulses plus a held target-hit mask at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module game_collision_detector
   import game_collision_pkg::*;
#(
   parameter int PIXEL_THRESHOLD = 4,
   parameter int CNT_W           = 8
) (
   input  wire logic                clk,
   input  wire logic                rst,
   game_collision_detector_if.slave bus
);

   collision_state_t     r_state;
   collision_state_t     w_next_state;
   logic                 w_report;
   logic                 w_accum;
   logic                 w_pix;
   logic                 w_clr;
   logic                 w_ship_inc;
   logic                 w_ship_over;
   logic [N_TARGETS-1:0] w_bullet_inc;
   logic [N_TARGETS-1:0] w_bullet_over;
   logic [CNT_W-1:0]     w_ship_count;
   logic [CNT_W-1:0]     w_bullet_count [N_TARGETS];

   logic                 r_collision;
   logic                 r_collision_bullet;
   logic [N_TARGETS-1:0] r_hit_target;
   logic                 r_armed;

   // ------------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= WAIT_FRAME;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A clear coinciding with frame_start suppresses the report entirely.
   always_comb begin
      w_next_state = r_state;
      w_report     = 1'b0;
      case (r_state)
         WAIT_FRAME: begin
            if (bus.frame_start) begin
               w_next_state = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.frame_start && !bus.clear) begin
               w_report = 1'b1;
            end
         end
         default: begin
            w_next_state = WAIT_FRAME;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Overlap decode
   // ------------------------------------------------------------------------
   assign w_accum    = (r_state == ACCUM);
   assign w_pix      = w_accum & bus.pixel_valid;
   assign w_clr      = w_accum & (bus.frame_start | bus.clear);
   assign w_ship_inc = w_pix & bus.spaceship_rgb_en & (|bus.target_rgb_en);

   game_overlap_counter #(
      .CNT_W           (CNT_W),
      .PIXEL_THRESHOLD (PIXEL_THRESHOLD)
   ) u_ship_cnt (
      .clk            (clk),
      .rst            (rst),
      .inc            (w_ship_inc),
      .clr            (w_clr),
      .count          (w_ship_count),
      .over_threshold (w_ship_over)
   );

   generate
      for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_bullet_cnt
         assign w_bullet_inc[gi] = w_pix & bus.bullet_rgb_en & bus.target_rgb_en[gi];

         game_overlap_counter #(
            .CNT_W           (CNT_W),
            .PIXEL_THRESHOLD (PIXEL_THRESHOLD)
         ) u_bullet_cnt (
            .clk            (clk),
            .rst            (rst),
            .inc            (w_bullet_inc[gi]),
            .clr            (w_clr),
            .count          (w_bullet_count[gi]),
            .over_threshold (w_bullet_over[gi])
         );
      end : g_bullet_cnt
   endgenerate

   // Raw counts are only needed for debug visibility, not for the report.
   logic w_unused_counts;
   assign w_unused_counts = ^{w_ship_count, w_bullet_count[0],
                              w_bullet_count[1], w_bullet_count[2]};

   // ------------------------------------------------------------------------
   // Report registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_collision        <= 1'b0;
         r_collision_bullet <= 1'b0;
         r_hit_target       <= '0;
         r_armed            <= 1'b0;
      end else begin
         r_collision        <= w_report & w_ship_over;
         r_collision_bullet <= w_report & (|w_bullet_over);
         if (w_report) begin
            r_hit_target <= w_bullet_over;
         end
         if (bus.frame_start) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign bus.collision        = r_collision;
   assign bus.collision_bullet = r_collision_bullet;
   assign bus.hit_target       = r_hit_target;
   assign bus.armed            = r_armed;

endmodule : game_collision_detector
`default_nettype wire

// File: tb/tb_game_collision_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_game_collision_detector
// Description : Directed bench; DUT a uses default widths, DUT b uses CNT_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_collision_detector;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   game_collision_detector_if bus_a ();
   game_collision_detector_if bus_b ();

   game_collision_detector #(.PIXEL_THRESHOLD(4), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   game_collision_detector #(.PIXEL_THRESHOLD(4), .CNT_W(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic fs, input logic pv,
                        input logic sh, input logic bu,
                        input logic [2:0] tg, input logic cl);
      if (!sel) begin
         bus_a.frame_start = fs; bus_a.pixel_valid = pv;
         bus_a.spaceship_rgb_en = sh; bus_a.bullet_rgb_en = bu;
         bus_a.target_rgb_en = tg; bus_a.clear = cl;
      end else begin
         bus_b.frame_start = fs; bus_b.pixel_valid = pv;
         bus_b.spaceship_rgb_en = sh; bus_b.bullet_rgb_en = bu;
         bus_b.target_rgb_en = tg; bus_b.clear = cl;
      end
   endtask

   task automatic cyc(input bit sel, input logic fs, input logic pv,
                      input logic sh, input logic bu,
                      input logic [2:0] tg, input logic cl);
      drive(sel, fs, pv, sh, bu, tg, cl);
      tick();
      drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
   endtask

   task automatic pixels(input bit sel, input int n, input logic sh,
                         input logic bu, input logic [2:0] tg);
      for (int i = 0; i < n; i++) cyc(sel, 1'b0, 1'b1, sh, bu, tg, 1'b0);
   endtask

   task automatic frame(input bit sel);
      cyc(sel, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
   endtask

   // Expected packing: {collision, collision_bullet, hit_target[2:0], armed}
   task automatic chk(input bit sel, input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      if (!sel) obs = {bus_a.collision, bus_a.collision_bullet, bus_a.hit_target, bus_a.armed};
      else      obs = {bus_b.collision, bus_b.collision_bullet, bus_b.hit_target, bus_b.armed};
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed {col,colb,hit,armed}=%b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      tick();
      tick();
      chk(1'b0, "reset_a", 6'b0_0_000_0);
      chk(1'b1, "reset_b", 6'b0_0_000_0);
      rst = 1'b0;

      // Pixels before the first frame_start are ignored; first boundary only arms.
      pixels(1'b0, 10, 1'b1, 1'b0, 3'b010);
      chk(1'b0, "wait_ignores_pixels", 6'b0_0_000_0);
      frame(1'b0);
      chk(1'b0, "first_frame_arms", 6'b0_0_000_1);

      // Ship hits target 2 exactly at threshold; pulse lasts one cycle.
      pixels(1'b0, 4, 1'b1, 1'b0, 3'b010);
      frame(1'b0);
      chk(1'b0, "ship_hit_pulse", 6'b1_0_000_1);
      tick();
      chk(1'b0, "ship_pulse_one_cycle", 6'b0_0_000_1);

      // Bullet: 3 on target 1 (below), 5 on target 3 (above).
      pixels(1'b0, 3, 1'b0, 1'b1, 3'b001);
      pixels(1'b0, 5, 1'b0, 1'b1, 3'b100);
      frame(1'b0);
      chk(1'b0, "bullet_hit_t3", 6'b0_1_100_1);
      pixels(1'b0, 2, 1'b0, 1'b1, 3'b001);
      chk(1'b0, "hit_mask_held", 6'b0_0_100_1);
      frame(1'b0);
      chk(1'b0, "hit_mask_reload_zero", 6'b0_0_000_1);

      // Ship and bullet both over two targets on the same pixels.
      pixels(1'b0, 4, 1'b1, 1'b1, 3'b011);
      frame(1'b0);
      chk(1'b0, "both_pulses_multi_target", 6'b1_1_011_1);

      // clear with frame_start wins: no report, mask untouched.
      pixels(1'b0, 6, 1'b1, 1'b0, 3'b001);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      chk(1'b0, "clear_with_frame_start", 6'b0_0_011_1);
      frame(1'b0);
      chk(1'b0, "empty_frame_report", 6'b0_0_000_1);

      // Mid-frame clear discards earlier pixels (3 + 3 would otherwise hit).
      pixels(1'b0, 3, 1'b1, 1'b0, 3'b100);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      pixels(1'b0, 3, 1'b1, 1'b0, 3'b100);
      frame(1'b0);
      chk(1'b0, "mid_frame_clear", 6'b0_0_000_1);

      // Pixel coincident with frame_start belongs to the new frame.
      pixels(1'b0, 3, 1'b1, 1'b0, 3'b100);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0);
      chk(1'b0, "fs_pixel_not_in_old_frame", 6'b0_0_000_1);
      pixels(1'b0, 3, 1'b1, 1'b0, 3'b100);
      frame(1'b0);
      chk(1'b0, "fs_pixel_in_new_frame", 6'b1_0_000_1);

      // Asynchronous reset mid-frame.
      pixels(1'b0, 4, 1'b0, 1'b1, 3'b100);
      frame(1'b0);
      chk(1'b0, "pre_reset_hit", 6'b0_1_100_1);
      pixels(1'b0, 5, 1'b1, 1'b0, 3'b001);
      #3;
      rst = 1'b1;
      #1;
      chk(1'b0, "async_reset_immediate", 6'b0_0_000_0);
      tick();
      rst = 1'b0;
      pixels(1'b0, 5, 1'b1, 1'b0, 3'b001);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      chk(1'b0, "clear_in_wait_no_effect", 6'b0_0_000_0);
      frame(1'b0);
      chk(1'b0, "post_reset_arm_no_report", 6'b0_0_000_1);
      frame(1'b0);
      chk(1'b0, "post_reset_empty_frame", 6'b0_0_000_1);

      // Narrow counters (CNT_W=3) must saturate at 7 rather than wrap.
      frame(1'b1);
      chk(1'b1, "b_arm", 6'b0_0_000_1);
      pixels(1'b1, 20, 1'b1, 1'b0, 3'b010);
      frame(1'b1);
      chk(1'b1, "b_sat20_pulse", 6'b1_0_000_1);
      tick();
      chk(1'b1, "b_pulse_one_cycle", 6'b0_0_000_1);
      frame(1'b1);
      chk(1'b1, "b_no_overlap_frame", 6'b0_0_000_1);
      pixels(1'b1, 19, 1'b1, 1'b0, 3'b001);
      frame(1'b1);
      chk(1'b1, "b_sat19_no_wrap", 6'b1_0_000_1);
      pixels(1'b1, 19, 1'b0, 1'b1, 3'b010);
      frame(1'b1);
      chk(1'b1, "b_bullet_sat19", 6'b0_1_010_1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_game_collision_detector
`default_nettype wire

// File: doc/game_collision_detector.md
# game_collision_detector

Frame-level collision detector that sits directly upstream of the game master FSM. It watches the per-pixel sprite enables from the spaceship, bullet and three target sprite units during active video. It counts overlapping pixels over one frame and, at the next frame boundary, emits single-cycle `collision` / `collision_bullet` pulses plus a held per-target hit mask. Emitting one pulse per frame, rather than a level that stays high for the whole overlap, ensures the FSM decrements lives or increments score at most once per frame.

## Interface
Parameters:
- `PIXEL_THRESHOLD`, default 4: minimum overlapping pixels in one frame to declare a hit. Legal range is 1 .. 2^CNT_W-1.
- `CNT_W`, default 8: width of each overlap counter.

Ports:
- `clk`  in  1  system/pixel clock
- `rst`  in  1  reset; asynchronous, active-high
- `frame_start`  in  1  one-cycle pulse at the start of each frame; always asserted in blanking
- `pixel_valid`  in  1  high during the active display area
- `spaceship_rgb_en`  in  1  spaceship sprite covers the current pixel
- `bullet_rgb_en`  in  1  bullet sprite covers the current pixel
- `target_rgb_en`  in  3  bit i: target i+1 covers the current pixel
- `clear`  in  1  one-cycle request to discard the current frame's accumulation; FSM pulses it when sprites are repositioned
- `collision`  out  1  one-cycle pulse: spaceship overlapped any target in the last frame
- `collision_bullet`  out  1  one-cycle pulse: bullet overlapped any target in the last frame
- `hit_target`  out  3  bit i: bullet hit target i+1 in the last reported frame; held until the next report
- `armed`  out  1  high once the first `frame_start` after reset has been seen

## Operation
State machine with two states:
- WAIT_FRAME (reset state): pixels are ignored and counters are held at 0. On `frame_start`, go to ACCUM. No report is made on this first boundary.
- ACCUM: accumulate overlaps; on each `frame_start`, evaluate, report, and clear the counters.

Per-pixel accumulation, only when `pixel_valid` is high and the state is ACCUM:
- `ship_cnt` += 1 when `spaceship_rgb_en & |target_rgb_en`.
- `bullet_cnt[i]` += 1 when `bullet_rgb_en & target_rgb_en[i]`, for i = 0..2.
- All counters saturate at 2^CNT_W-1 and never wrap.
- If the bullet overlaps several targets on the same pixel, each of the corresponding counters increments.

Evaluation on `frame_start` while in ACCUM:
- `collision` = `ship_cnt >= PIXEL_THRESHOLD`.
- `hit_target[i]` = `bullet_cnt[i] >= PIXEL_THRESHOLD`; `collision_bullet` = `|hit_target`.
- Both pulses may fire in the same cycle. Prioritising between them is the consumer's job.
- `hit_target` is loaded on every report, including with all zeros.

Boundary conditions:
- `frame_start` and `pixel_valid` high in the same cycle: the pixel is counted into the new frame, after the clear. This case does not occur with a compliant timing source.
- `clear` with `frame_start` in the same cycle: `clear` wins. Counters go to 0, no pulse is issued, `hit_target` is unchanged, and the state stays ACCUM.
- `clear` in WAIT_FRAME: no effect.
- `rst` mid-frame: all state, counters and outputs return to reset values immediately. The next `frame_start` only arms the block and produces no report.
- `frame_start` with zero pixels in the frame: a report is issued with all flags 0.

## Timing
- Reset values: `collision` = 0, `collision_bullet` = 0, `hit_target` = 3'b000, `armed` = 0, all counters = 0, state = WAIT_FRAME.
- Pixel-to-counter latency is 1 cycle, registered.
- A report appears as registered outputs in the cycle after the `frame_start` cycle. The pulses are exactly 1 cycle wide, and `hit_target` updates on that same edge.
- `armed` rises in the cycle after the first `frame_start`.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Structure
- Package `game_collision_pkg` holds:
  - the state enum `collision_state_t` {WAIT_FRAME, ACCUM};
  - `N_TARGETS` = 3.
- Sub-module `game_overlap_counter`: saturating counter with parameters `CNT_W` and `PIXEL_THRESHOLD`.
  - Inputs: `clk`, `rst`, `inc`, `clr`.
  - Outputs: `count` and registered-free compare `over_threshold`.
  - Instantiated 1 + N_TARGETS times.
- The top level contains the FSM, the overlap decode, and the output registers.

## Test plan
- Reset, then the first `frame_start` with 10 overlapping ship/target pixels before it → no pulse, `armed` = 1 the next cycle.
- Armed; frame with 4 pixels of ship∩target_2, then `frame_start` → `collision` = 1 for exactly 1 cycle, `collision_bullet` = 0, `hit_target` = 000.
- Armed; frame with 3 pixels of bullet∩target_1 and 5 pixels of bullet∩target_3 → `collision_bullet` pulse, `hit_target` = 3'b100, held through the next frame's accumulation.
- `CNT_W` = 3, 20 overlap pixels → counter saturates at 7, `collision` pulses once; the next frame has no overlap → no pulse, `hit_target` = 000.
- 6 overlap pixels, then `clear` and `frame_start` in the same cycle → no pulse; the following empty frame → no pulse.
- Overlap accumulating, `rst` asserted mid-frame → outputs 0 immediately; the next `frame_start` → no report, `armed` = 1.
